sequence_generator: RTL and testbench
=====================================

// Module: sequence_generator
// PURPOSE
//   Serial pattern transmitter: the driving end of the serial bit line that the
//   sequence detector samples.
//   Latches a pattern of up to MAX_LEN bits and shifts it out MSB-first, one bit
//   per step tick. It can repeat the pattern N times with a programmable run of
//   zero bits between copies.
//   Feeds the detector's w input on the lab board, or a bench.
// PARAMETERS
//   MAX_LEN  8  max pattern length in bits
//   LEN_W    4  width of length/repeats/gap fields; must hold MAX_LEN
// PORTS
//   clock       in   1        single clock, rising edge
//   reset       in   1        synchronous, active-high; all state cleared at the clock edge
//   start       in   1        request; sampled only in IDLE
//   abort       in   1        drop the current transfer and return to IDLE
//   step        in   1        bit-rate enable; FSM advances only when 1 (IDLE excepted)
//   pattern     in   MAX_LEN  bits; the bit at index length-1 is sent first
//   length      in   LEN_W    bits per copy; 0 = nothing sent; >MAX_LEN clamped to MAX_LEN
//   repeats     in   LEN_W    number of copies; 0 treated as 1
//   gap         in   LEN_W    zero bits inserted between copies (not after the last)
//   serial_out  out  1        transmitted bit
//   valid       out  1        1 while serial_out carries a pattern bit
//   busy        out  1        1 from the cycle after start is accepted until done
//   done        out  1        one-cycle pulse at the end of the transfer
//   state       out  2        current state, for LEDs
// BEHAVIOUR
//   Reset: state=IDLE; serial_out=valid=busy=done=0; all internal counters 0.
//   States: IDLE=0, SEND=1, GAP=2, DONE=3. Moore outputs: decoded from registers
//     only, with no combinational path from inputs to outputs.
//   IDLE: on start=1, latch the inputs at that edge: pat, len (clamped), reps
//     (0->1) and gp. Set idx=len-1. Go to SEND, or to DONE if len==0.
//     IDLE ignores step.
//   SEND: serial_out=pat[idx]; valid=1. On step:
//     - idx>0: idx <= idx-1.
//     - idx==0 and reps==1: go to DONE.
//     - idx==0 and reps>1: reps <= reps-1. Then:
//       - gp==0: idx <= len-1 and stay in SEND (back-to-back copies).
//       - gp>0: gcnt <= gp-1 and go to GAP.
//   GAP: serial_out=0; valid=0. On step: if gcnt==0, idx <= len-1 and go to
//     SEND; else gcnt <= gcnt-1.
//   DONE: done=1 for exactly one cycle (independent of step), then IDLE;
//     serial_out=0.
//   busy = (state==SEND or state==GAP). The DONE cycle shows busy=0.
//   Each bit is held from entry into SEND (or from the previous step) until the
//     next step. With step tied to 1, one bit is sent per clock; first bit on
//     the cycle after start.
//   start while busy: ignored. Inputs changing mid-transfer: no effect (only
//     latched copies are used).
//   abort: from SEND or GAP, go to IDLE next edge. No done pulse; outputs 0.
//     abort has no effect in IDLE or DONE.
//   reset mid-transfer: IDLE at the next edge. Reset wins over abort, start
//     and step.
//   start and abort together in IDLE: start wins (abort is a no-op in IDLE).
//   Counter widths: idx and gcnt are LEN_W bits and never wrap below 0, because
//     a decrement only happens when the counter is nonzero.
// STRUCTURE
//   Shared package seq_pkg holds:
//     - state localparams IDLE/SEND/GAP/DONE (2-bit)
//     - MAX_LEN and LEN_W defaults, shared with sequence_detector builds
//   Sub-module seq_down_counter: LEN_W-bit down-counter with load, enable and
//     zero flag. Instantiated twice, once for idx and once for gcnt.
//   Top level: state register, next-state case, and output decode.
// TESTING
//   1. pattern=8'b0000_1101, len=4, reps=1, step=1, start pulse
//      -> serial_out 1,1,0,1 on cycles 1-4 with valid=1; done on cycle 5.
//   2. pattern=8'b11, len=2, reps=3, gap=2, step=1
//      -> 1,1,0,0,1,1,0,0,1,1 with valid low during the zeros; one done pulse.
//   3. len=3, step pulsed every 4th cycle
//      -> each bit held 4 cycles; start again while busy -> ignored, no second
//         transfer.
//   4. len=0, start -> DONE next cycle; done=1 for 1 cycle; valid never 1.
//   5. abort after 2 bits of an 8-bit send -> IDLE next edge, no done. A new
//      start then works. Reset mid-GAP -> all outputs 0 next edge.
//   6. len=12 (>MAX_LEN) -> 8 bits sent. reps=0 -> exactly one copy.
//      Loopback into sequence_detector with its target pattern -> detector
//      output asserts.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the matching detector builds.
package seq_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_LEN_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/seq_down_counter.sv
// Down-counter with synchronous load and a decrement that saturates at zero.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches a pattern and shifts it out MSB-first,
// one bit per step tick, optionally repeating it with zero-bit gaps in between.
module sequence_generator #(
  parameter int MAX_LEN = seq_pkg::DEF_MAX_LEN,
  parameter int LEN_W   = seq_pkg::DEF_LEN_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               step,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [LEN_W-1:0]   repeats,
  input  logic [LEN_W-1:0]   gap,
  output logic               serial_out,
  output logic               valid,
  output logic               busy,
  output logic               done,
  output logic [1:0]         state
);

  import seq_pkg::*;

  // Handshake: start is accepted only in IDLE (busy=0); step is a bit-rate
  // strobe consumed in SEND/GAP; valid qualifies serial_out; done pulses once.
  state_t               state_q, state_d;
  logic [MAX_LEN-1:0]   pat_q;
  logic [LEN_W-1:0]     len_q, reps_q, gp_q;
  logic [LEN_W-1:0]     len_clamp, reps_in;
  logic [LEN_W-1:0]     idx, gcnt;
  logic [LEN_W-1:0]     idx_load_val;
  logic [MAX_LEN-1:0]   bit_sh;
  logic                 idx_zero, gcnt_zero;
  logic                 idx_load, idx_dec, gcnt_load, gcnt_dec, reps_dec;
  logic                 accept;

  assign len_clamp = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
  assign reps_in   = (repeats == '0) ? LEN_W'(1) : repeats;
  assign accept    = (state_q == IDLE) && start;

  always_comb begin
    state_d      = state_q;
    idx_load     = 1'b0;
    idx_load_val = len_q - LEN_W'(1);
    idx_dec      = 1'b0;
    gcnt_load    = 1'b0;
    gcnt_dec     = 1'b0;
    reps_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_load_val = len_clamp - LEN_W'(1);
          idx_load     = (len_clamp != '0);
          state_d      = (len_clamp == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          if (!idx_zero) begin
            idx_dec = 1'b1;
          end else if (reps_q == LEN_W'(1)) begin
            state_d = DONE;
          end else begin
            reps_dec = 1'b1;
            if (gp_q == '0) begin
              idx_load = 1'b1;
            end else begin
              gcnt_load = 1'b1;
              state_d   = GAP;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step) begin
          if (gcnt_zero) begin
            idx_load = 1'b1;
            state_d  = SEND;
          end else begin
            gcnt_dec = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      reps_q  <= '0;
      gp_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pat_q  <= pattern;
        len_q  <= len_clamp;
        reps_q <= reps_in;
        gp_q   <= gap;
      end else if (reps_dec) begin
        reps_q <= reps_q - LEN_W'(1);
      end
    end
  end

  seq_down_counter #(.W(LEN_W)) u_idx (
    .clock    (clock),
    .reset    (reset),
    .load     (idx_load),
    .dec      (idx_dec),
    .load_val (idx_load_val),
    .count    (idx),
    .zero     (idx_zero)
  );

  seq_down_counter #(.W(LEN_W)) u_gcnt (
    .clock    (clock),
    .reset    (reset),
    .load     (gcnt_load),
    .dec      (gcnt_dec),
    .load_val (gp_q - LEN_W'(1)),
    .count    (gcnt),
    .zero     (gcnt_zero)
  );

  // Outputs depend only on registered state, so no input-to-output path exists.
  assign bit_sh     = pat_q >> idx;
  assign serial_out = (state_q == SEND) && bit_sh[0];
  assign valid      = (state_q == SEND);
  assign busy       = (state_q == SEND) || (state_q == GAP);
  assign done       = (state_q == DONE);
  assign state      = state_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: per-cycle expected output words
// are queued from an independent stream model and compared as the DUT runs.
module tb_sequence_generator;

  logic       clock = 1'b0;
  logic       reset, start, abort, step;
  logic [7:0] pattern;
  logic [3:0] length, repeats, gap;
  logic       serial_out, valid, busy, done;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  // Word layout: {state[1:0], busy, valid, serial_out, done}
  logic [5:0] exp_q[$];

  sequence_generator dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .step       (step),
    .pattern    (pattern),
    .length     (length),
    .repeats    (repeats),
    .gap        (gap),
    .serial_out (serial_out),
    .valid      (valid),
    .busy       (busy),
    .done       (done),
    .state      (state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [5:0] obs();
    return {state, busy, valid, serial_out, done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transfer with step asserted every h-th cycle; optional second start while
  // busy (must be ignored) and abort raised together with start (start wins).
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                      input logic [3:0] g, input int h, input bit restart, input bit ab);
    int effl, effr, t;
    logic [5:0] e;
    effl = (l > 4'd8) ? 8 : int'(l);
    effr = (r == 4'd0) ? 1 : int'(r);
    if (effl > 0) begin
      for (int c = 0; c < effr; c++) begin
        for (int b = effl - 1; b >= 0; b--)
          repeat (h) exp_q.push_back({2'd1, 1'b1, 1'b1, p[b], 1'b0});
        if (c < effr - 1)
          repeat (int'(g) * h) exp_q.push_back({2'd2, 1'b1, 1'b0, 1'b0, 1'b0});
      end
    end
    exp_q.push_back({2'd3, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_q.push_back(6'd0);

    pattern = p; length = l; repeats = r; gap = g;
    start = 1'b1; abort = ab; step = (h == 1);
    tick();
    start = 1'b0; abort = 1'b0;
    t = 1;
    while (exp_q.size() > 0) begin
      step    = ((t % h) == 0);
      pattern = 8'($urandom);
      length  = 4'($urandom);
      repeats = 4'($urandom);
      gap     = 4'($urandom);
      start   = restart && (t == 3);
      e = exp_q.pop_front();
      check_eq("stream", obs(), e);
      tick();
      t++;
    end
    start = 1'b0;
    step  = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; step = 1'b1;
    pattern = '0; length = '0; repeats = '0; gap = '0;
    tick(); tick();
    check_eq("reset", obs(), 6'd0);
    start = 1'b1;
    tick();
    check_eq("reset_over_start", obs(), 6'd0);
    reset = 1'b0; start = 1'b0;
    tick();

    send(8'b0000_1101, 4'd4, 4'd1, 4'd0, 1, 1'b0, 1'b0);
    send(8'b0000_0011, 4'd2, 4'd3, 4'd2, 1, 1'b0, 1'b0);
    send(8'b0000_0101, 4'd3, 4'd1, 4'd0, 4, 1'b1, 1'b0);
    send(8'hff, 4'd0, 4'd2, 4'd1, 1, 1'b0, 1'b0);
    send(8'b1011_0010, 4'd12, 4'd0, 4'd3, 1, 1'b0, 1'b0);
    send(8'b0000_0110, 4'd3, 4'd2, 4'd0, 1, 1'b0, 1'b1);

    // abort after two bits of an 8-bit send
    pattern = 8'b1010_0101; length = 4'd8; repeats = 4'd1; gap = 4'd0;
    start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0;
    check_eq("abort_bit0", obs(), {2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    check_eq("abort_bit1", obs(), {2'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    abort = 1'b1;
    tick();
    check_eq("abort_idle", obs(), 6'd0);
    tick();
    check_eq("abort_in_idle", obs(), 6'd0);
    abort = 1'b0;
    send(8'b0000_1001, 4'd4, 4'd1, 4'd0, 1, 1'b0, 1'b0);

    // reset during a gap, together with start and step
    pattern = 8'b0000_0010; length = 4'd2; repeats = 4'd2; gap = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rg_bit0", obs(), {2'd1, 1'b1, 1'b1, 1'b1, 1'b0});
    tick();
    check_eq("rg_bit1", obs(), {2'd1, 1'b1, 1'b1, 1'b0, 1'b0});
    tick();
    check_eq("rg_gap", obs(), {2'd2, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b1; start = 1'b1; step = 1'b1;
    tick();
    check_eq("rg_reset", obs(), 6'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    check_eq("rg_after", obs(), 6'd0);
    send(8'b0000_0001, 4'd1, 4'd2, 4'd1, 1, 1'b0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      send(8'($urandom), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 2)), $urandom_range(1, 3), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
